// File: rtl/fifo_rd_burst_adapter_if.sv
// fifo_rd_burst_adapter_if: read side of the FWFT FIFO plus the valid/ready
// output stream of the burst adapter, bundled into one interface.
interface fifo_rd_burst_adapter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_empty;
    logic [ADDR_WIDTH:0]   fifo_depth;
    logic                  fifo_ren;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    // Adapter side: pops the FIFO and sources the output stream.
    modport master (
        input  fifo_data_out, fifo_empty, fifo_depth, m_ready,
        output fifo_ren, m_data, m_valid
    );

    // Environment side: the FIFO being drained and the stream consumer.
    modport slave (
        output fifo_data_out, fifo_empty, fifo_depth, m_ready,
        input  fifo_ren, m_data, m_valid
    );
endinterface

// File: rtl/fifo_rd_burst_adapter.sv
// fifo_rd_burst_adapter: drains a first-word-fall-through FIFO in bursts
// (threshold, timeout or flush triggered) into a 2-entry output skid buffer.
// Optional build macro ADAPTER_STATS_EN adds the word_count output, a
// saturating count of words delivered on the stream.
module fifo_rd_burst_adapter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    output logic busy,
`ifdef ADAPTER_STATS_EN
    output logic [31:0] word_count,
`endif
    fifo_rd_burst_adapter_if.master bus
);
    localparam int BCW = $clog2(BURST_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam logic [BCW-1:0]      BURST_LAST  = BCW'(BURST_LEN - 1);
    localparam logic [BCW-1:0]      BURST_MAX   = BCW'(BURST_LEN);
    localparam logic [TCW-1:0]      TMO_LAST    = TCW'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0] BURST_DEPTH = (ADDR_WIDTH + 1)'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [TCW-1:0]        tmo_q, tmo_d;
    logic [BCW-1:0]        burst_q, burst_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] skid0_q, skid0_d;
    logic [DATA_WIDTH-1:0] skid1_q, skid1_d;
    logic                  ren;
    logic                  pop;
    logic                  depth_hit;
`ifdef ADAPTER_STATS_EN
    logic [31:0]           word_count_q, word_count_d;
`endif

    // Pop only while draining and only when the skid buffer has room, so a
    // stalled consumer can never cause a word to be dropped.
    assign ren       = ~reset & (state_q == DRAIN) & ~bus.fifo_empty & (occ_q != 2'd2);
    assign pop       = (occ_q != 2'd0) & bus.m_ready;
    assign depth_hit = (bus.fifo_depth >= BURST_DEPTH);

    assign bus.fifo_ren = ren;
    assign bus.m_valid  = (occ_q != 2'd0);
    assign bus.m_data   = skid0_q;
    assign busy         = (state_q == DRAIN) | (occ_q != 2'd0);
`ifdef ADAPTER_STATS_EN
    assign word_count   = word_count_q;
`endif

    // Burst policy: wait in ACCUM for threshold/timeout/flush, then pop a
    // burst of BURST_LEN words (unbounded while flush is held).
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    if (depth_hit || flush) begin
                        state_d = DRAIN;
                        burst_d = '0;
                    end else begin
                        state_d = ACCUM;
                        tmo_d   = '0;
                    end
                end
            end
            ACCUM: begin
                if (bus.fifo_empty) begin
                    state_d = IDLE;
                end else if (depth_hit || flush || (tmo_q == TMO_LAST)) begin
                    state_d = DRAIN;
                    burst_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DRAIN: begin
                if (bus.fifo_empty && !flush) begin
                    state_d = IDLE;
                end else if (ren) begin
                    if (!flush && (burst_q >= BURST_LAST)) begin
                        state_d = IDLE;
                    end else if (burst_q != BURST_MAX) begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry skid buffer: head in skid0, overflow in skid1, FIFO order kept
    // on simultaneous push and pop.
    always_comb begin
        skid0_d = skid0_q;
        skid1_d = skid1_q;
        occ_d   = occ_q;
        case (occ_q)
            2'd0: begin
                if (ren) begin
                    skid0_d = bus.fifo_data_out;
                    occ_d   = 2'd1;
                end
            end
            2'd1: begin
                if (ren && pop) begin
                    skid0_d = bus.fifo_data_out;
                end else if (ren) begin
                    skid1_d = bus.fifo_data_out;
                    occ_d   = 2'd2;
                end else if (pop) begin
                    occ_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    skid0_d = skid1_q;
                    occ_d   = 2'd1;
                end
            end
        endcase
    end

`ifdef ADAPTER_STATS_EN
    // Delivered-word counter, saturating rather than wrapping.
    always_comb begin
        word_count_d = word_count_q;
        if (pop && (word_count_q != 32'hFFFF_FFFF)) begin
            word_count_d = word_count_q + 32'd1;
        end
    end
`endif

    // State registers; reset discards anything held in the skid buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tmo_q        <= '0;
            burst_q      <= '0;
            occ_q        <= 2'd0;
            skid0_q      <= '0;
            skid1_q      <= '0;
`ifdef ADAPTER_STATS_EN
            word_count_q <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            burst_q      <= burst_d;
            occ_q        <= occ_d;
            skid0_q      <= skid0_d;
            skid1_q      <= skid1_d;
`ifdef ADAPTER_STATS_EN
            word_count_q <= word_count_d;
`endif
        end
    end
endmodule
